// File: rtl/serial_tx_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_tx_fifo_if : producer write port plus serial_tx launch handshake
// rev 1.0
// ---------------------------------------------------------------------------
interface serial_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic [7:0]          sbyte;
  logic                sbyte_rdy;
  logic                end_of_send;
  logic                busy;

  modport master (
    output wr_data, wr_en, end_of_send,
    input  full, empty, level, overflow, sbyte, sbyte_rdy, busy
  );

  modport slave (
    input  wr_data, wr_en, end_of_send,
    output full, empty, level, overflow, sbyte, sbyte_rdy, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_tx_fifo : byte FIFO that paces serial_tx one character at a time
// rev 1.0
// ---------------------------------------------------------------------------
module serial_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk12,
  input  logic            reset,
  serial_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [GAP_W-1:0]    GAP_LOAD   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_POP  = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic [7:0]            sbyte;
  logic [2:0]            state;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // full comes from the registered level, so a same-cycle pop never frees a slot early
  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign push  = bus.wr_en && !full;
  assign pop   = (state == S_POP);

  always_ff @(posedge clk12) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      sbyte    <= 8'h00;
      state    <= S_IDLE;
      gap_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (bus.wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        sbyte  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      case (state)
        S_IDLE: begin
          if (level != '0) begin
            state <= S_POP;
          end
        end
        S_POP:  state <= S_SEND;
        S_SEND: state <= S_WAIT;
        S_WAIT: begin
          if (bus.end_of_send) begin
            if (GAP_CYCLES == 0) begin
              state <= S_IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.sbyte     = sbyte;
  assign bus.sbyte_rdy = (state == S_SEND);
  assign bus.busy      = (state != S_IDLE) || (level != '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_tx_fifo : scoreboard bench for serial_tx_fifo (gap 0 and gap 5)
// rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_tx_fifo;

  logic clk;
  logic reset;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  serial_tx_fifo_if #(.DEPTH_LOG2(4)) b0 ();
  serial_tx_fifo_if #(.DEPTH_LOG2(4)) b1 ();

  serial_tx_fifo #(.DEPTH_LOG2(4), .GAP_CYCLES(0)) dut0 (
    .clk12 (clk),
    .reset (reset),
    .bus   (b0)
  );

  serial_tx_fifo #(.DEPTH_LOG2(4), .GAP_CYCLES(5)) dut1 (
    .clk12 (clk),
    .reset (reset),
    .bus   (b1)
  );

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_eos[2]    = '{1'b0, 1'b0};
  logic       spur[2]     = '{1'b0, 1'b0};
  int         cnt[2]      = '{0, 0};
  int         last_eos[2] = '{-1, -1};
  int         last_rdy[2] = '{-1, -1};
  int         exp_rdy[2]  = '{-1, -1};
  int         spacing[2]  = '{3, 8};
  bit         b2b[2]      = '{1'b0, 1'b0};

  assign b0.end_of_send = m_eos[0] | spur[0];
  assign b1.end_of_send = m_eos[1] | spur[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor plus serial_tx model: end_of_send 20 clocks after each launch
  task automatic mon_cycle(input int k);
    logic       rdy;
    logic [7:0] sb;
    logic [7:0] exp;
    bit         have;
    rdy  = (k == 0) ? b0.sbyte_rdy : b1.sbyte_rdy;
    sb   = (k == 0) ? b0.sbyte : b1.sbyte;
    have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (rdy) begin
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch dut%0d: sbyte_rdy=1 sbyte=0x%0h, expected no launch", k, sb);
      end else begin
        exp = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sbyte_dut%0d", k), {24'h0, sb}, {24'h0, exp});
      end
      if (exp_rdy[k] >= 0) begin
        chk($sformatf("launch_latency_dut%0d", k), cyc, exp_rdy[k]);
        exp_rdy[k] = -1;
      end
      if (b2b[k] && last_eos[k] >= 0 && last_eos[k] > last_rdy[k]) begin
        chk($sformatf("launch_spacing_dut%0d", k), cyc - last_eos[k], spacing[k]);
      end
      last_rdy[k] = cyc;
    end
    m_eos[k] = 1'b0;
    if (cnt[k] > 0) begin
      cnt[k]--;
      if (cnt[k] == 0) begin
        m_eos[k]    = 1'b1;
        last_eos[k] = cyc;
      end
    end
    if (rdy) begin
      cnt[k] = 20;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_cycle(0);
      mon_cycle(1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input int k, input logic [7:0] d, input bit accept);
    if (k == 0) begin
      b0.wr_data = d;
      b0.wr_en   = 1'b1;
      if (accept) q0.push_back(d);
    end else begin
      b1.wr_data = d;
      b1.wr_en   = 1'b1;
      if (accept) q1.push_back(d);
    end
    tick(1);
    b0.wr_en = 1'b0;
    b1.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int limit, output int at);
    int n;
    n = 0;
    while (((k == 0) ? b0.busy : b1.busy) && n < limit) begin
      tick(1);
      n++;
    end
    at = cyc;
    chk($sformatf("idle_timeout_dut%0d", k), {31'h0, (k == 0) ? b0.busy : b1.busy}, 32'h0);
  endtask

  initial begin
    int c;
    int at;
    reset      = 1'b1;
    b0.wr_en   = 1'b0;
    b0.wr_data = 8'h00;
    b1.wr_en   = 1'b0;
    b1.wr_data = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Reset state
    chk("rst_level",    {27'h0, b0.level}, 32'h0);
    chk("rst_full",     {31'h0, b0.full}, 32'h0);
    chk("rst_empty",    {31'h0, b0.empty}, 32'h1);
    chk("rst_overflow", {31'h0, b0.overflow}, 32'h0);
    chk("rst_sbyte",    {24'h0, b0.sbyte}, 32'h0);
    chk("rst_rdy",      {31'h0, b0.sbyte_rdy}, 32'h0);
    chk("rst_busy",     {31'h0, b0.busy}, 32'h0);

    // 1. Single-byte latency
    c = cyc;
    exp_rdy[0] = c + 3;
    put(0, 8'h48, 1'b1);
    chk("t1_level", {27'h0, b0.level}, 32'h1);
    chk("t1_busy",  {31'h0, b0.busy}, 32'h1);
    wait_idle(0, 100, at);
    chk("t1_busy_fall_cycle", at, c + 24);

    // 2. Fill and overflow while the reader is parked in S_WAIT
    put(0, 8'hAA, 1'b1);
    tick(4);
    last_eos[0] = -1;
    b2b[0]      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      put(0, 8'(i), 1'b1);
    end
    chk("t2_full",         {31'h0, b0.full}, 32'h1);
    chk("t2_level",        {27'h0, b0.level}, 32'h10);
    chk("t2_overflow_pre", {31'h0, b0.overflow}, 32'h0);
    put(0, 8'h10, 1'b0);
    chk("t2_overflow",     {31'h0, b0.overflow}, 32'h1);
    chk("t2_level_hold",   {27'h0, b0.level}, 32'h10);
    wait_idle(0, 700, at);
    chk("t2_empty",         {31'h0, b0.empty}, 32'h1);
    chk("t2_overflow_held", {31'h0, b0.overflow}, 32'h1);

    // 3. Write during transmission
    last_eos[0] = -1;
    put(0, 8'h48, 1'b1);
    put(0, 8'h69, 1'b1);
    chk("t3_level_peak", {27'h0, b0.level}, 32'h2);
    tick(4);
    chk("t3_level_wait", {27'h0, b0.level}, 32'h1);
    put(0, 8'h21, 1'b1);
    chk("t3_level_again", {27'h0, b0.level}, 32'h2);
    wait_idle(0, 200, at);
    b2b[0] = 1'b0;

    // 4. Inter-character gap on the GAP_CYCLES=5 instance
    last_eos[1] = -1;
    b2b[1]      = 1'b1;
    exp_rdy[1]  = cyc + 3;
    put(1, 8'h55, 1'b1);
    put(1, 8'hC3, 1'b1);
    wait_idle(1, 200, at);
    chk("t4_q1_drained", q1.size(), 32'h0);

    // 5. Reset during the first S_WAIT
    put(0, 8'h11, 1'b1);
    put(0, 8'h22, 1'b1);
    put(0, 8'h33, 1'b1);
    put(0, 8'h44, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    q0.delete();
    chk("t5_level",    {27'h0, b0.level}, 32'h0);
    chk("t5_full",     {31'h0, b0.full}, 32'h0);
    chk("t5_empty",    {31'h0, b0.empty}, 32'h1);
    chk("t5_overflow", {31'h0, b0.overflow}, 32'h0);
    chk("t5_sbyte",    {24'h0, b0.sbyte}, 32'h0);
    tick(30);
    chk("t5_busy_after_late_eos", {31'h0, b0.busy}, 32'h0);

    // 6. Spurious end_of_send, then pointer wrap
    spur[0] = 1'b1;
    tick(1);
    spur[0] = 1'b0;
    chk("t6_spur_busy", {31'h0, b0.busy}, 32'h0);
    tick(3);
    chk("t6_spur_busy_later", {31'h0, b0.busy}, 32'h0);
    for (int i = 0; i < 40; i++) begin
      put(0, 8'(i * 7 + 3), 1'b1);
      tick(24);
    end
    wait_idle(0, 100, at);
    chk("t6_overflow", {31'h0, b0.overflow}, 32'h0);
    chk("t6_empty",    {31'h0, b0.empty}, 32'h1);

    chk("final_q0_drained", q0.size(), 32'h0);
    chk("final_q1_drained", q1.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
